my_chip: RTL and testbench
==========================

Name: my_chip

Overview:
- Serial-loaded 8x8 unsigned multiply-accumulate chip behind a 12-bit pad-style interface (io_in/io_out).
- Operands A and B are shifted in MSB-first on strobed pin pairs. A do_next strobe multiplies A by B and adds the product to a 20-bit accumulator.
- After NUM_OPS accumulations the chip raises finish, and the accumulator is shifted out serially, LSB-first.

Parameters:
- WIDTH, 8: operand width in bits.
- ACC_WIDTH, 20: accumulator width and serial-out length.
- NUM_OPS, 9: number of accumulations before finish.

Ports:
- clock  input  1  single system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in  input  12  [11]=start, [10]=shiftA, [9]=shiftB, [8]=shift, [7]=do_next, [6:0] ignored.
- io_out  output  12  [11]=mac_carry_out, [10]=finish, [9]=shiftout, [8]=end_mul, [7:0] tied 0.

Behaviour:
- Input conditioning:
  - All five used io_in bits pass through 2-flop synchronizers.
  - start, shift and do_next act on their synchronized rising edge only (one event per strobe, regardless of strobe length).
  - shiftA and shiftB are sampled synchronized, on the same cycle as the shift edge.
- Reset (reset=0, async): all registers 0, state IDLE, every io_out bit 0.
- States: IDLE, LOAD, MUL, DONE.
- IDLE: shift and do_next ignored. A start edge clears A, B, the accumulator, the op count, carry and end_mul, then goes to LOAD.
- LOAD:
  - shift edge: A <= {A[WIDTH-2:0], shiftA}; B <= {B[WIDTH-2:0], shiftB}; end_mul <= 0.
  - do_next edge: go to MUL.
- MUL:
  - Sequential shift-add multiply, one partial-product step per clock, WIDTH cycles; produces a 16-bit unsigned product.
  - On completion: {carry, acc} <= acc + product, with carry sticky-ORed into mac_carry_out.
  - Also on completion: op count +1 and end_mul <= 1.
  - Next state is DONE if the count reaches NUM_OPS, else LOAD.
  - shift and do_next edges are ignored during MUL.
  - A and B are not cleared after a multiply; each new operand fully overwrites them after WIDTH shifts.
- DONE:
  - finish=1 (level).
  - shiftout = acc[0] continuously; each shift edge does acc <= acc >> 1 (zero fill).
  - do_next is ignored.
  - A start edge clears the same state as in IDLE and re-enters LOAD.
- shiftout is 0 outside DONE.
- Latency from pin change to register update is at most 4 clocks. Strobes must be held at least 2 clocks, and at least 2 clocks low between strobes.
- A start edge in LOAD or MUL aborts the current run and restarts: clear, then LOAD.
- Simultaneous shift and do_next edges in LOAD: the shift applies first, then MUL.
- Reset mid-operation returns to IDLE with all outputs 0.
- With defaults the maximum sum is 9*65025=585225, so no carry occurs. Carry is only reachable with larger NUM_OPS.

Decomposition:
- Package my_chip_pkg: state enum (IDLE, LOAD, MUL, DONE), default WIDTH/ACC_WIDTH/NUM_OPS constants, io bit-index localparams.
- One sub-module, seq_multiplier: start/done handshake, WIDTH-cycle shift-add unsigned multiplier.
- Synchronizers and edge detectors are inline.

Test Plan:
- Basic MAC run:
  - Stimulus: reset low 15 clocks, release, start.
  - Then for i=0..8: shift in A=i+2, B=i+3, pulse do_next, end_mul=1 after each op.
  - Wait for finish, then shift out 20 bits LSB-first.
  - Required: result 438, carry 0.
- Maximum operands: 9 ops of A=255, B=255 -> result 585225 (0x8EE09), carry 0.
- Ignored strobes: shift and do_next strobes before any start -> state stays IDLE, finish=0, all outputs 0. A subsequent normal run is unaffected.
- Restart and reset mid-run:
  - start mid-run after 3 ops, then 9 ops of A=1, B=1 -> result 9.
  - Async reset asserted during MUL -> io_out=0 immediately.
- Overflow (NUM_OPS=17 override): 17 ops of 255x255 -> mac_carry_out=1, shifted-out 20 bits = 56849.
- Strobe-length independence: do_next held 3 clocks and shift held 5 clocks each produce exactly one event; result is unchanged versus the 2-clock strobes.

Source files
------------

// File: rtl/my_chip_pkg.sv
// ---------------------------------------------------------------------------
// my_chip_pkg
// Shared constants for the serial-loaded multiply-accumulate chip:
//   - default operand / accumulator widths and accumulation count
//   - FSM state encodings (IDLE, LOAD, MUL, DONE)
//   - bit positions of the strobes and flags on the 12-bit pad buses
// No ports; imported by my_chip and seq_multiplier.
// ---------------------------------------------------------------------------
package my_chip_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 20;
    localparam int DEF_NUM_OPS   = 9;

    // Encoded states kept as plain constants so older tools see simple vectors
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t MUL  = 2'd2;
    localparam state_t DONE = 2'd3;

    // io_in bit positions
    localparam int IN_START    = 11;
    localparam int IN_SHIFT_A  = 10;
    localparam int IN_SHIFT_B  = 9;
    localparam int IN_SHIFT    = 8;
    localparam int IN_DO_NEXT  = 7;

    // io_out bit positions
    localparam int OUT_CARRY    = 11;
    localparam int OUT_FINISH   = 10;
    localparam int OUT_SHIFTOUT = 9;
    localparam int OUT_END_MUL  = 8;

endpackage

// File: rtl/my_chip_seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Unsigned shift-add multiplier, one partial product per clock, WIDTH clocks
// per multiply.
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   i_start    one-cycle pulse; captures i_a / i_b and begins a multiply
//   i_a, i_b   WIDTH-bit unsigned operands
//   o_done     one-cycle pulse when o_product holds the finished result
//   o_product  2*WIDTH-bit product (stable until the next i_start)
// ---------------------------------------------------------------------------
module seq_multiplier
    import my_chip_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_product;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;

    // The multiplicand walks left while the multiplier walks right; each step
    // adds the multiplicand when the multiplier's current LSB is set. A new
    // i_start always wins, so an abandoned multiply is simply restarted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_product <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_product <= '0;
                r_mcand   <= {{WIDTH{1'b0}}, i_a};
                r_mplier  <= i_b;
                r_count   <= '0;
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_product <= r_product + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
                if (r_count == LAST_STEP) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: rtl/my_chip.sv
// ---------------------------------------------------------------------------
// my_chip
// Serial-loaded unsigned multiply-accumulate behind a 12-bit pad interface.
// Operands are shifted in MSB-first, each do_next multiplies and accumulates,
// and after NUM_OPS accumulations the sum is shifted out LSB-first.
// Ports:
//   clock   system clock, all state on the rising edge
//   reset   asynchronous active-low reset
//   io_in   [11]=start [10]=shiftA [9]=shiftB [8]=shift [7]=do_next
//           [6:0] unused
//   io_out  [11]=mac_carry_out [10]=finish [9]=shiftout [8]=end_mul
//           [7:0] tied low
// ---------------------------------------------------------------------------
module my_chip
    import my_chip_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int NUM_OPS   = DEF_NUM_OPS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);

    localparam int SUM_W = ACC_WIDTH + 1;
    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS);

    // Synchronizer bit order: 4=start 3=shiftA 2=shiftB 1=shift 0=do_next
    logic [4:0]           w_rawIn;
    logic [4:0]           r_sync1;
    logic [4:0]           r_sync2;
    logic                 r_prevStart;
    logic                 r_prevShift;
    logic                 r_prevDoNext;

    logic                 w_startEdge;
    logic                 w_shiftEdge;
    logic                 w_doNextEdge;
    logic                 w_shiftA;
    logic                 w_shiftB;
    logic                 w_unused;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_opCount;
    logic                 r_carry;
    logic                 r_endMul;

    logic [WIDTH-1:0]     w_aNext;
    logic [WIDTH-1:0]     w_bNext;
    logic                 w_mulStart;
    logic                 w_mulDone;
    logic [2*WIDTH-1:0]   w_product;
    logic [SUM_W-1:0]     w_sum;
    logic [CNT_W-1:0]     w_countNext;

    assign w_rawIn  = {io_in[IN_START], io_in[IN_SHIFT_A], io_in[IN_SHIFT_B],
                       io_in[IN_SHIFT], io_in[IN_DO_NEXT]};
    assign w_unused = ^io_in[6:0];

    // Two-flop synchronizers, plus one history flop per strobe so each strobe
    // yields a single event on its rising edge however long it is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_prevStart  <= 1'b0;
            r_prevShift  <= 1'b0;
            r_prevDoNext <= 1'b0;
        end else begin
            r_sync1      <= w_rawIn;
            r_sync2      <= r_sync1;
            r_prevStart  <= r_sync2[4];
            r_prevShift  <= r_sync2[1];
            r_prevDoNext <= r_sync2[0];
        end
    end

    assign w_startEdge  = r_sync2[4] & ~r_prevStart;
    assign w_shiftEdge  = r_sync2[1] & ~r_prevShift;
    assign w_doNextEdge = r_sync2[0] & ~r_prevDoNext;
    assign w_shiftA     = r_sync2[3];
    assign w_shiftB     = r_sync2[2];

    // Operand values after this cycle's shift. The multiplier takes these so
    // a shift and do_next landing together use the freshly shifted operands.
    assign w_aNext = w_shiftEdge ? {r_a[WIDTH-2:0], w_shiftA} : r_a;
    assign w_bNext = w_shiftEdge ? {r_b[WIDTH-2:0], w_shiftB} : r_b;

    assign w_mulStart  = (r_state == LOAD) && w_doNextEdge && !w_startEdge;
    assign w_sum       = {1'b0, r_acc} + SUM_W'(w_product);
    assign w_countNext = r_opCount + 1'b1;

    seq_multiplier #(
        .WIDTH     (WIDTH)
    ) u_multiplier (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_mulStart),
        .i_a       (w_aNext),
        .i_b       (w_bNext),
        .o_done    (w_mulDone),
        .o_product (w_product)
    );

    // Main control. A start edge restarts from any state; otherwise each state
    // only reacts to the strobes that mean something there. A multiply left
    // running by an aborted MUL finishes harmlessly while back in LOAD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_opCount <= '0;
            r_carry   <= 1'b0;
            r_endMul  <= 1'b0;
        end else if (w_startEdge) begin
            r_state   <= LOAD;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_opCount <= '0;
            r_carry   <= 1'b0;
            r_endMul  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                LOAD: begin
                    if (w_shiftEdge) begin
                        r_a      <= w_aNext;
                        r_b      <= w_bNext;
                        r_endMul <= 1'b0;
                    end
                    if (w_doNextEdge) begin
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    if (w_mulDone) begin
                        r_acc     <= w_sum[ACC_WIDTH-1:0];
                        r_carry   <= r_carry | w_sum[ACC_WIDTH];
                        r_opCount <= w_countNext;
                        r_endMul  <= 1'b1;
                        r_state   <= (w_countNext == LAST_OP) ? DONE : LOAD;
                    end
                end
                DONE: begin
                    if (w_shiftEdge) begin
                        r_acc <= r_acc >> 1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        io_out               = '0;
        io_out[OUT_CARRY]    = r_carry;
        io_out[OUT_FINISH]   = (r_state == DONE);
        io_out[OUT_SHIFTOUT] = (r_state == DONE) & r_acc[0];
        io_out[OUT_END_MUL]  = r_endMul;
    end

endmodule

// File: tb/tb_my_chip.sv
// ---------------------------------------------------------------------------
// tb_my_chip
// Scoreboard bench for my_chip. Stimulus tasks push expected responses into
// queues; a monitor on the falling clock edge pops and compares whenever the
// chip presents an end_mul rising edge, a requested io_out snapshot, or a
// completed serial readout. Two instances: default NUM_OPS and NUM_OPS=17.
// ---------------------------------------------------------------------------
module tb_my_chip;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] ioIn0 = '0;
    logic [11:0] ioIn1 = '0;
    logic [11:0] ioOut0;
    logic [11:0] ioOut1;
    logic [11:0] ioOutSel;
    int          cur = 0;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard queues
    logic [1:0]  opQ[$];
    logic [11:0] snapQ[$];
    string       snapNameQ[$];
    int          resQ[$];
    string       resNameQ[$];
    int          obsQ[$];
    logic        snapReq = 1'b0;
    logic        prevEnd = 1'b0;
    int          opSeen  = 0;

    always #5 clock = ~clock;

    assign ioOutSel = (cur == 0) ? ioOut0 : ioOut1;

    my_chip u_dut0 (
        .clock  (clock),
        .reset  (reset),
        .io_in  (ioIn0),
        .io_out (ioOut0)
    );

    my_chip #(
        .NUM_OPS (17)
    ) u_dut1 (
        .clock  (clock),
        .reset  (reset),
        .io_in  (ioIn1),
        .io_out (ioOut1)
    );

    // Monitor: compares DUT responses against the queued expectations
    always @(negedge clock) begin
        logic [1:0]  eFlags;
        logic [11:0] eSnap;
        string       nm;
        int          eRes;
        int          oRes;
        if (ioOutSel[8] && !prevEnd) begin
            opSeen = opSeen + 1;
            compared = compared + 1;
            if (opQ.size() == 0) begin
                mismatched = mismatched + 1;
                $display("[TB] FAIL unexpected_end_mul: got end_mul rise #%0d, none expected", opSeen);
            end else begin
                eFlags = opQ.pop_front();
                if ({ioOutSel[11], ioOutSel[10]} !== eFlags) begin
                    mismatched = mismatched + 1;
                    $display("[TB] FAIL op_flags #%0d: got {carry,finish}=%b, want %b",
                             opSeen, {ioOutSel[11], ioOutSel[10]}, eFlags);
                end
            end
        end
        prevEnd = ioOutSel[8];
        if (snapReq && snapQ.size() > 0) begin
            eSnap = snapQ.pop_front();
            nm = snapNameQ.pop_front();
            snapReq = 1'b0;
            compared = compared + 1;
            if (ioOutSel !== eSnap) begin
                mismatched = mismatched + 1;
                $display("[TB] FAIL %s: got io_out=0x%03h, want 0x%03h", nm, ioOutSel, eSnap);
            end
        end
        if (obsQ.size() > 0 && resQ.size() > 0) begin
            oRes = obsQ.pop_front();
            eRes = resQ.pop_front();
            nm = resNameQ.pop_front();
            compared = compared + 1;
            if (oRes != eRes) begin
                mismatched = mismatched + 1;
                $display("[TB] FAIL %s: got result=%0d, want %0d", nm, oRes, eRes);
            end
        end
    end

    task automatic setIn(input int bitIdx, input logic v);
        if (cur == 0) ioIn0[bitIdx] = v;
        else          ioIn1[bitIdx] = v;
    endtask

    // Raise a strobe for 'hold' clocks, then keep it low for 3 clocks
    task automatic strobe(input int bitIdx, input int hold);
        @(posedge clock); #1;
        setIn(bitIdx, 1'b1);
        repeat (hold) @(posedge clock);
        #1;
        setIn(bitIdx, 1'b0);
        repeat (3) @(posedge clock);
    endtask

    // One shift strobe carrying a bit for A and B
    task automatic shiftBits(input logic aBit, input logic bBit, input int hold);
        @(posedge clock); #1;
        setIn(10, aBit);
        setIn(9, bBit);
        setIn(8, 1'b1);
        repeat (hold) @(posedge clock);
        #1;
        setIn(8, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        setIn(10, 1'b0);
        setIn(9, 1'b0);
    endtask

    task automatic waitEndMul(input string nm);
        int n;
        n = 0;
        while (!ioOutSel[8] && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!ioOutSel[8]) begin
            compared = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s_timeout: got end_mul=0 after %0d clocks, want 1", nm, n);
        end
        repeat (2) @(posedge clock);
    endtask

    // Load one operand pair MSB-first and run one multiply-accumulate
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input int shHold, input int dnHold,
                                 input logic [1:0] expFlags);
        opQ.push_back(expFlags);
        for (int i = 7; i >= 0; i--) begin
            shiftBits(a[i], b[i], shHold);
        end
        strobe(7, dnHold);
        waitEndMul("op");
    endtask

    // Ask the monitor to compare io_out at the next falling edge
    task automatic checkOutput(input logic [11:0] expVal, input string nm);
        snapQ.push_back(expVal);
        snapNameQ.push_back(nm);
        snapReq = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic readResult(input int expVal, input string nm);
        int v;
        v = 0;
        resQ.push_back(expVal);
        resNameQ.push_back(nm);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ioOutSel[9]) v = v | (1 << k);
            shiftBits(1'b0, 1'b0, 2);
        end
        obsQ.push_back(v);
        repeat (3) @(posedge clock);
    endtask

    // Basic run operand tables: A = i+2, B = i+3
    logic [7:0] basicA [9] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    logic [7:0] basicB [9] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};

    initial begin
        $display("[TB] start");
        reset = 1'b0;
        repeat (15) @(posedge clock);
        checkOutput(12'h000, "reset_state");
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);

        // Strobes before any start must be ignored
        shiftBits(1'b1, 1'b1, 2);
        strobe(7, 2);
        repeat (20) @(posedge clock);
        checkOutput(12'h000, "idle_ignores_strobes");

        // Basic run: expect 438
        strobe(11, 2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(basicA[i], basicB[i], 2, 2, (i == 8) ? 2'b01 : 2'b00);
        end
        checkOutput(12'h500, "basic_done_flags");
        readResult(438, "basic_result");

        // Maximum operands: expect 585225
        strobe(11, 2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'd255, 8'd255, 2, 2, (i == 8) ? 2'b01 : 2'b00);
        end
        checkOutput(12'h700, "max_done_flags");
        readResult(585225, "max_result");

        // Restart after 3 ops, then 9 ops of 1x1: expect 9
        strobe(11, 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(basicA[i], basicB[i], 2, 2, 2'b00);
        end
        strobe(11, 2);
        checkOutput(12'h000, "restart_cleared");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'd1, 8'd1, 2, 2, (i == 8) ? 2'b01 : 2'b00);
        end
        checkOutput(12'h700, "restart_done_flags");
        readResult(9, "restart_result");

        // Long strobes: one event each, result unchanged
        strobe(11, 4);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(basicA[i], basicB[i], 5, 3, (i == 8) ? 2'b01 : 2'b00);
        end
        checkOutput(12'h500, "long_strobe_flags");
        readResult(438, "long_strobe_result");

        // Async reset during MUL
        strobe(11, 2);
        for (int i = 7; i >= 0; i--) begin
            shiftBits(1'b1, 1'b1, 2);
        end
        @(posedge clock); #1;
        setIn(7, 1'b1);
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        setIn(7, 1'b0);
        checkOutput(12'h000, "reset_mid_mul");
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        strobe(7, 2);
        repeat (25) @(posedge clock);
        checkOutput(12'h000, "idle_after_reset");

        // Overflow on the NUM_OPS=17 instance
        cur = 1;
        repeat (2) @(posedge clock);
        strobe(11, 2);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'd255, 8'd255, 2, 2, (i == 16) ? 2'b11 : 2'b00);
        end
        checkOutput(12'hF00, "overflow_done_flags");
        readResult(56849, "overflow_result");
        checkOutput(12'hD00, "overflow_after_shiftout");
        #1 reset = 1'b0;
        checkOutput(12'h000, "reset_in_done");
        #1 reset = 1'b1;
        repeat (5) @(posedge clock);

        if (opQ.size() != 0) begin
            compared = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL pending_ops: got %0d ops outstanding, want 0", opQ.size());
        end
        if (resQ.size() != 0 || snapQ.size() != 0) begin
            compared = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL pending_checks: got %0d results and %0d snapshots outstanding, want 0",
                     resQ.size(), snapQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
